// File: rtl/seg_scan_driver_if.sv
// Bundles the digit-update inputs and display drive outputs of seg_scan_driver.
// Latency: none (wires only).
// Backpressure: none; upd is a fire-and-forget strobe.
interface seg_scan_driver_if;
  logic [15:0] digits_in;
  logic        upd;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  // Source of digit updates; observes the display drive.
  modport master (
    output digits_in, upd, dp_in, blank_lz,
    input  an, seg, dp, frame_done
  );

  // The scan driver itself.
  modport slave (
    input  digits_in, upd, dp_in, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with frame-synchronous update and leading-zero blanking.
// Latency: new digits appear from slot 0 of the frame after upd (display reload only at frame boundary).
// Backpressure: none; upd is always accepted, a later upd in the same frame overwrites the shadow.
module seg_scan_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [1:0]       slot;
  logic [15:0]      shadow_dig;
  logic [3:0]       shadow_dp;
  logic [15:0]      disp_dig;
  logic [3:0]       disp_dp;
  logic             frame_end;

  logic [3:0]       nib;
  logic [6:0]       seg_lut;
  logic [3:0]       lz;
  logic [3:0]       blank_vec;

  assign frame_end = (pre == PRE_MAX) && (slot == 2'd3);

  // Prescaler and slot counter; slot steps each time the prescaler wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      slot <= 2'd0;
    end else if (pre == PRE_MAX) begin
      pre  <= '0;
      slot <= slot + 2'd1;
    end else begin
      pre  <= pre + 1'b1;
    end
  end

  // Shadow register captures every update strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else if (bus.upd) begin
      shadow_dig <= bus.digits_in;
      shadow_dp  <= bus.dp_in;
    end
  end

  // Display register reloads only at frame end; an update on that same cycle bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_dig <= '0;
      disp_dp  <= '0;
    end else if (frame_end) begin
      disp_dig <= bus.upd ? bus.digits_in : shadow_dig;
      disp_dp  <= bus.upd ? bus.dp_in     : shadow_dp;
    end
  end

  // BCD to active-low segments; codes above 9 render as a dash.
  always_comb begin
    nib = disp_dig[{slot, 2'b00} +: 4];
    case (nib)
      4'd0:    seg_lut = 7'b1000000;
      4'd1:    seg_lut = 7'b1111001;
      4'd2:    seg_lut = 7'b0100100;
      4'd3:    seg_lut = 7'b0110000;
      4'd4:    seg_lut = 7'b0011001;
      4'd5:    seg_lut = 7'b0010010;
      4'd6:    seg_lut = 7'b0000010;
      4'd7:    seg_lut = 7'b1111000;
      4'd8:    seg_lut = 7'b0000000;
      4'd9:    seg_lut = 7'b0010000;
      default: seg_lut = 7'b0111111;
    endcase
  end

  // Leading-zero chain from the top digit down; a set dp bit keeps its digit lit, digit0 always lit.
  always_comb begin
    lz        = 4'b0000;
    lz[3]     = (disp_dig[15:12] == 4'd0);
    lz[2]     = lz[3] && (disp_dig[11:8] == 4'd0);
    lz[1]     = lz[2] && (disp_dig[7:4] == 4'd0);
    blank_vec = {4{bus.blank_lz}} & lz & ~disp_dp;
  end

  // Output drive: dark while pre=0 (ghost guard, also covers reset), otherwise the selected digit.
  always_comb begin
    bus.an  = 4'b1111;
    bus.seg = 7'b1111111;
    bus.dp  = 1'b1;
    if ((pre != '0) && !blank_vec[slot]) begin
      bus.an  = ~(4'b0001 << slot);
      bus.seg = seg_lut;
      bus.dp  = ~disp_dp[slot];
    end
  end

  assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_DIV=4 (16-cycle frames).
// Expected per-slot drives are queued when updates are issued and compared as slots are scanned.
// Frame pulse and ghost guard are checked every cycle against an independent position counter.
module tb_seg_scan_driver;

  logic clk;
  logic rst_n;

  seg_scan_driver_if bus_if ();

  seg_scan_driver #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int         frame;
    int         slot;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } sb_t;

  sb_t q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  int  bpre;
  int  bslot;
  int  bframe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan position tracker: 4 cycles per slot, 4 slots per frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bpre   <= 0;
      bslot  <= 0;
      bframe <= 0;
    end else if (bpre == 3) begin
      bpre <= 0;
      if (bslot == 3) begin
        bslot  <= 0;
        bframe <= bframe + 1;
      end else begin
        bslot <= bslot + 1;
      end
    end else begin
      bpre <= bpre + 1;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic sb_t mk(input int fr, input int s, input logic [15:0] d,
                             input logic [3:0] dpv, input logic blz);
    sb_t  e;
    logic z;
    logic [3:0] one;
    z = 1'b1;
    for (int k = 3; k >= s; k--) z = z && (d[k*4 +: 4] == 4'd0);
    e.frame = fr;
    e.slot  = s;
    one     = 4'b0001;
    if (blz && (s != 0) && z && !dpv[s]) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
    end else begin
      e.an  = ~(one << s);
      e.seg = seg_of(d[s*4 +: 4]);
      e.dp  = ~dpv[s];
    end
    return e;
  endfunction

  task automatic push_frame(input int fr, input logic [15:0] d, input logic [3:0] dpv,
                            input logic blz);
    for (int s = 0; s < 4; s++) q.push_back(mk(fr, s, d, dpv, blz));
  endtask

  // Called #1 after a posedge; returns #1 after the posedge where the scan sits at (fr, s, p).
  task automatic wait_to(input int fr, input int s, input int p);
    int n;
    n = 0;
    while (!(bframe == fr && bslot == s && bpre == p) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("wait_timeout", 32'(n), 32'd0);
  endtask

  // Pulse upd for exactly one clock edge.
  task automatic do_upd(input logic [15:0] d, input logic [3:0] dpv);
    bus_if.digits_in = d;
    bus_if.dp_in     = dpv;
    bus_if.upd       = 1'b1;
    @(posedge clk);
    #1;
    bus_if.upd       = 1'b0;
  endtask

  // Per-cycle monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("frame_done", 32'(bus_if.frame_done), 32'((bpre == 3) && (bslot == 3)));
      if (bpre == 0) begin
        chk("ghost_an", 32'(bus_if.an), 32'h0000000F);
      end else if (q.size() > 0) begin
        if ((q[0].frame * 4 + q[0].slot) < (bframe * 4 + bslot)) begin
          chk("sb_stale", 32'(bframe * 4 + bslot), 32'(q[0].frame * 4 + q[0].slot));
          void'(q.pop_front());
        end else if (q[0].frame == bframe && q[0].slot == bslot) begin
          chk("slot_an",  32'(bus_if.an),  32'(q[0].an));
          chk("slot_seg", 32'(bus_if.seg), 32'(q[0].seg));
          chk("slot_dp",  32'(bus_if.dp),  32'(q[0].dp));
          if (bpre == 3) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    rst_n              = 1'b0;
    bus_if.digits_in   = 16'h8888;
    bus_if.dp_in       = 4'hF;
    bus_if.upd         = 1'b1;
    bus_if.blank_lz    = 1'b0;

    // Reset state with clock running and upd held high.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an",  32'(bus_if.an),         32'h0000000F);
    chk("rst_seg", 32'(bus_if.seg),        32'h0000007F);
    chk("rst_dp",  32'(bus_if.dp),         32'd1);
    chk("rst_fd",  32'(bus_if.frame_done), 32'd0);
    bus_if.upd = 1'b0;
    rst_n      = 1'b1;
    push_frame(0, 16'h0000, 4'h0, 1'b0);

    // Plain update mid-frame.
    wait_to(0, 1, 2);
    do_upd(16'h1234, 4'h0);
    push_frame(1, 16'h1234, 4'h0, 1'b0);

    // Update in slot 1: current frame keeps old digits.
    wait_to(1, 1, 1);
    do_upd(16'h5678, 4'b0100);
    push_frame(2, 16'h5678, 4'b0100, 1'b0);

    // Bypass on the frame-boundary cycle, then leading-zero blanking.
    wait_to(2, 3, 3);
    do_upd(16'h0007, 4'h0);
    bus_if.blank_lz = 1'b1;
    push_frame(3, 16'h0007, 4'h0, 1'b1);

    wait_to(3, 3, 3);
    do_upd(16'h0000, 4'h0);
    push_frame(4, 16'h0000, 4'h0, 1'b1);

    wait_to(4, 3, 3);
    do_upd(16'h00A0, 4'b0100);
    push_frame(5, 16'h00A0, 4'b0100, 1'b1);

    wait_to(5, 3, 3);
    do_upd(16'h9F30, 4'b1001);
    bus_if.blank_lz = 1'b0;
    push_frame(6, 16'h9F30, 4'b1001, 1'b0);

    // Pending shadow update, then reset in slot 2 discards it.
    wait_to(6, 1, 1);
    do_upd(16'h1234, 4'hF);
    wait_to(6, 2, 2);
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_an",  32'(bus_if.an),         32'h0000000F);
    chk("mid_rst_seg", 32'(bus_if.seg),        32'h0000007F);
    chk("mid_rst_dp",  32'(bus_if.dp),         32'd1);
    chk("mid_rst_fd",  32'(bus_if.frame_done), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_rst_an",  32'(bus_if.an),  32'h0000000F);
      chk("hold_rst_seg", 32'(bus_if.seg), 32'h0000007F);
    end
    rst_n = 1'b1;
    push_frame(0, 16'h0000, 4'h0, 1'b0);
    push_frame(1, 16'h0000, 4'h0, 1'b0);

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SCAN_DIV, 50000, clock cycles per digit slot; the block SHALL support any value from 4 to 2^20.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 digits_in  input  16  four BCD digits; [3:0] is digit0 (least significant) and [15:12] is digit3.
REQ-005 upd  input  1  one-cycle strobe that captures digits_in and dp_in into the shadow register.
REQ-006 dp_in  input  4  decimal-point request per digit; bit k belongs to digit k.
REQ-007 blank_lz  input  1  leading-zero blanking enable; it is sampled live, not shadowed.
REQ-008 an  output  4  anode selects, active-low; an[k] drives digit k.
REQ-009 seg  output  7  segment drives, active-low; seg[0]=a through seg[6]=g.
REQ-010 dp  output  1  decimal-point drive, active-low.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each complete 4-digit frame.

Function
REQ-012 The prescaler `pre` SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-013 When `pre` wraps, the slot counter `slot` (2 bits) SHALL advance 0->1->2->3->0.
REQ-014 One frame SHALL last 4*SCAN_DIV cycles.
REQ-015 On a clk edge where upd=1, the shadow register SHALL load digits_in and dp_in; otherwise it holds.
REQ-016 The display register SHALL load from the shadow only at the frame boundary, defined as pre=SCAN_DIV-1 with slot=3. This prevents tearing within a frame.
REQ-017 If upd=1 on the frame-boundary cycle, the display register SHALL load digits_in and dp_in directly (bypass), so the new value appears from slot 0 of the next frame.
REQ-018 frame_done SHALL be 1 exactly on the frame-boundary cycle and 0 on all other cycles.
REQ-019 an, seg and dp SHALL be combinational decodes of registered state (pre, slot, display register) and blank_lz only; there SHALL be no path from digits_in, dp_in or upd to the outputs.
REQ-020 Ghost guard: while pre=0, an SHALL be 4'b1111.
REQ-021 While pre!=0, an SHALL drive only an[slot] low, and seg/dp SHALL show the display digit selected by slot.
REQ-022 BCD decode, seg={g,f,e,d,c,b,a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-023 Nibble values 10-15 SHALL display a dash, seg=0111111.
REQ-024 dp SHALL be the inverse of display dp bit [slot].
REQ-025 Leading-zero blanking, when blank_lz=1:
  - digit k (k=3,2,1) SHALL be blanked when it and every more-significant digit equal 0.
  - a blanked digit SHALL hold an=1111, seg=1111111 and dp=1 for its slot, unless its dp bit is set; in that case the digit is not blanked.
  - digit0 SHALL never be blanked.
REQ-026 Counters SHALL wrap silently; the block has no error outputs.

Reset
REQ-027 While rst_n=0, regardless of clk, the block SHALL force:
  - pre=0, slot=0
  - shadow and display registers = 0
  - an=1111, seg=1111111, dp=1, frame_done=0
REQ-028 Reset asserted mid-frame SHALL abandon the frame. No frame_done SHALL pulse for it, and pending shadow contents SHALL be lost.
REQ-029 After rst_n rises, the first clk edge SHALL increment pre from 0, and slot 0 SHALL be the first slot displayed.

Verification (run with SCAN_DIV=4)
REQ-030 Reset: drop rst_n for 3 cycles in slot 2 -> outputs take the reset values immediately; after release, the first active slot is 0 with an=1110 at pre=1.
REQ-031 Update and decode: upd with digits_in=16'h1234, dp_in=0, blank_lz=0 -> from the next frame:
  - slot0 seg=0011001, slot1 seg=0110000, slot2 seg=0100100, slot3 seg=1111001
  - dp=1 throughout.
REQ-032 Leading-zero blanking: digits_in=16'h0007, blank_lz=1 -> slots 1-3 keep an=1111 and slot0 shows seg=1111000.
REQ-033 Zero and dash: digits_in=16'h0000 with blank_lz=1 -> slot0 shows 1000000. A nibble of 4'hA -> that slot shows 0111111.
REQ-034 Anti-tearing: upd asserted in slot 1 -> slots 2-3 still show the old digits, and the new value starts in slot 0 of the next frame.
REQ-035 Bypass: upd asserted on the frame_done cycle -> the new value is shown in the next frame's slot 0.
REQ-036 Frame timing: frame_done pulses every 16 cycles, and an=1111 on every pre=0 cycle.
